multi_cycle_control: RTL
========================

// Module: multi_cycle_control
// PURPOSE
//  Sequencing FSM for the multi-cycle RISC-V core; replaces the combinational Control unit.
//  Breaks each instruction into FETCH/DECODE/EXEC/MEM/WB steps and drives the datapath enables.
//  Waits on ready handshakes from program and data memory, counts retired instructions and
//  traps on illegal opcodes or memory timeouts.
// PARAMETERS
//  INSTRET_WIDTH  32  width of retired-instruction counter
//  MEM_TIMEOUT    16  max wait cycles for IMem/DMem ready before trap (>=2)
// PORTS
//  clk            in   1   core clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  Opcode_i       in   7   instruction[6:0] from instruction register
//  Branch_Taken_i in   1   ALU result bit 0 (compare outcome)
//  IMem_Ready_i   in   1   program memory data valid
//  DMem_Ready_i   in   1   data memory access complete
//  IMem_Read_o    out  1   program memory read request
//  IR_Write_o     out  1   load instruction register
//  PC_Write_o     out  1   load PC register
//  PC_Src_o       out  2   0 PC+4, 1 PC+imm, 2 ALU result (JALR)
//  ALU_Src_o      out  1   0 rs2, 1 immediate
//  ALU_Op_o       out  3   ALU_Control operation class
//  Mem_Read_o     out  1   data memory read request
//  Mem_Write_o    out  1   data memory write request
//  Reg_Write_o    out  1   register file write enable
//  Wb_Sel_o       out  2   0 ALU, 1 memory, 2 PC+4
//  Trap_o         out  1   sticky fault flag
//  Instret_o      out  INSTRET_WIDTH  retired instruction count
//  State_o        out  3   current state (debug)
// BEHAVIOUR
//  Reset (async, reset=0): state FETCH, every strobe/select 0, Trap_o 0, Instret_o 0, timer 0.
//  Strobes are combinational from registered state + Opcode_i; state/counters change on clk.
//  Legal opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011,
//   JAL 1101111, JALR 1100111, LUI 0110111; anything else is illegal.
//  FETCH: IMem_Read_o=1; when IMem_Ready_i: IR_Write_o=1 that cycle, -> DECODE.
//  DECODE: illegal -> TRAP, else -> EXEC. No strobes.
//  EXEC: LOAD/STORE -> MEM; BRANCH -> FETCH with PC_Write_o=1, PC_Src_o=Branch_Taken_i?1:0,
//   Instret+1; all others -> WB.
//  MEM: Mem_Read_o (LOAD) or Mem_Write_o (STORE) held until DMem_Ready_i. On ready: LOAD -> WB;
//   STORE -> FETCH with PC_Write_o=1, PC_Src_o=0, Instret+1.
//  WB: Reg_Write_o=1 one cycle; Wb_Sel_o=1 LOAD, 2 JAL/JALR, else 0; PC_Write_o=1 with
//   PC_Src_o=1 JAL, 2 JALR, else 0; Instret+1; -> FETCH.
//  ALU_Src_o/ALU_Op_o: function of Opcode_i only, held constant in DECODE/EXEC/MEM/WB; 0 in FETCH.
//  Latency (ready same cycle): BRANCH 3, R/I/LUI/JAL/JALR/STORE 4, LOAD 5 cycles.
//  Timer: cleared on entry to FETCH/MEM; counts each cycle ready is low; at MEM_TIMEOUT-1 with
//   ready still low -> TRAP. Ready in the timeout cycle wins (normal transition).
//  TRAP: Trap_o=1, all strobes 0, Instret frozen; leaves only via reset.
//  Instret wraps 2^INSTRET_WIDTH-1 -> 0. Exactly one PC_Write_o pulse per retired instruction.
//  Reset mid-access: strobes drop asynchronously, no write completes, state FETCH.
// STRUCTURE
//  Package riscv_ctrl_pkg: opcode constants, state encoding (FETCH..TRAP), ALU_Op codes,
//   PC_Src/Wb_Sel encodings; shared with ALU_Control and Immediate_Unit.
//  Sub-module wait_timer: clearable saturating counter with expiry flag, width clog2(MEM_TIMEOUT).
// TESTING
//  ADD (0110011), both readies=1 -> states F,D,E,WB; Reg_Write_o high cycle 4 only, Instret 0->1.
//  LOAD, DMem_Ready_i low 3 cycles -> Mem_Read_o high 4 cycles, then WB with Wb_Sel_o=1.
//  BRANCH, Branch_Taken_i=1 in EXEC -> PC_Write_o=1, PC_Src_o=1, Reg_Write_o never asserted.
//  Opcode 0000000 -> TRAP cycle after DECODE; Trap_o=1, strobes 0 for 100 cycles until reset.
//  IMem_Ready_i=0 for MEM_TIMEOUT=16 cycles -> TRAP; ready on 16th cycle -> DECODE, no trap.
//  reset=0 mid STORE wait -> Mem_Write_o 0 same cycle, State_o FETCH, Instret_o 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control path.
// Holds opcode constants, the sequencer state encoding, ALU operation
// classes and the PC / write-back source selects. Also used by
// ALU_Control and Immediate_Unit.
package riscv_ctrl_pkg;

    // Base opcodes (instruction[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Sequencer states, exported on State_o for debug
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    // ALU operation classes consumed by ALU_Control
    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,  // address / link arithmetic
        ALU_CMP   = 3'd1,  // branch compare
        ALU_RTYPE = 3'd2,  // decode funct3/funct7
        ALU_ITYPE = 3'd3,  // decode funct3 (immediate form)
        ALU_PASS  = 3'd4   // pass immediate (LUI)
    } alu_op_e;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_IMM   = 2'd1;
    localparam logic [1:0] PC_SRC_ALU   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

    typedef struct packed {
        logic    src;  // 0 rs2, 1 immediate
        alu_op_e op;
    } alu_ctrl_t;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    // ALU operand select and operation class as a pure function of opcode.
    function automatic alu_ctrl_t alu_ctrl(input logic [6:0] op);
        alu_ctrl_t c;
        c.src = 1'b0;
        c.op  = ALU_ADD;
        case (op)
            OP_R:      c.op = ALU_RTYPE;
            OP_I:      begin c.src = 1'b1; c.op = ALU_ITYPE; end
            OP_LOAD:   c.src = 1'b1;
            OP_STORE:  c.src = 1'b1;
            OP_BRANCH: c.op = ALU_CMP;
            OP_JALR:   c.src = 1'b1;
            OP_LUI:    begin c.src = 1'b1; c.op = ALU_PASS; end
            default:   ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Clearable saturating wait counter with an expiry flag.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   clr_i      synchronous clear (priority over inc_i)
//   inc_i      count one waiting cycle
//   expired_o  count has reached LIMIT-1
module wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/multi_cycle_control.sv
// Sequencing FSM for the multi-cycle RISC-V core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath enables, waits on memory ready, counts retired instructions
// and traps (sticky until reset) on illegal opcodes or memory timeouts.
// Ports:
//   clk, reset (async, active-low)
//   Opcode_i, Branch_Taken_i, IMem_Ready_i, DMem_Ready_i      inputs
//   IMem_Read_o, IR_Write_o, PC_Write_o, PC_Src_o             fetch/PC control
//   ALU_Src_o, ALU_Op_o                                       ALU control
//   Mem_Read_o, Mem_Write_o, Reg_Write_o, Wb_Sel_o            data/WB control
//   Trap_o, Instret_o, State_o                                status / debug
//
// Handshake: a memory request strobe is held high every cycle of the wait;
// the access completes in the cycle where the matching ready is high.
module multi_cycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned INSTRET_WIDTH = 32,
    parameter int unsigned MEM_TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               Opcode_i,
    input  logic                     Branch_Taken_i,
    input  logic                     IMem_Ready_i,
    input  logic                     DMem_Ready_i,
    output logic                     IMem_Read_o,
    output logic                     IR_Write_o,
    output logic                     PC_Write_o,
    output logic [1:0]               PC_Src_o,
    output logic                     ALU_Src_o,
    output logic [2:0]               ALU_Op_o,
    output logic                     Mem_Read_o,
    output logic                     Mem_Write_o,
    output logic                     Reg_Write_o,
    output logic [1:0]               Wb_Sel_o,
    output logic                     Trap_o,
    output logic [INSTRET_WIDTH-1:0] Instret_o,
    output logic [2:0]               State_o
);

    state_e                   state_q, state_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

    logic       imem_read, ir_write, pc_write, alu_src;
    logic       mem_read, mem_write, reg_write;
    logic [1:0] pc_src, wb_sel;
    logic [2:0] alu_op;
    logic       timer_inc, timer_clr, timer_expired;
    alu_ctrl_t  alu_c;

    assign alu_c = alu_ctrl(Opcode_i);

    always_comb begin
        state_d   = state_q;
        imem_read = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_PLUS4;
        alu_src   = 1'b0;
        alu_op    = ALU_ADD;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_sel    = WB_SEL_ALU;
        timer_inc = 1'b0;

        // ALU controls track the opcode in every post-fetch working state.
        if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
            alu_src = alu_c.src;
            alu_op  = alu_c.op;
        end

        case (state_q)
            ST_FETCH: begin
                imem_read = 1'b1;
                // Ready in the expiry cycle still completes the fetch.
                if (IMem_Ready_i) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timer_expired) begin
                    state_d = ST_TRAP;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            ST_DECODE: begin
                state_d = is_legal(Opcode_i) ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                if (Opcode_i == OP_LOAD || Opcode_i == OP_STORE) begin
                    state_d = ST_MEM;
                end else if (Opcode_i == OP_BRANCH) begin
                    pc_write = 1'b1;
                    pc_src   = Branch_Taken_i ? PC_SRC_IMM : PC_SRC_PLUS4;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_read  = (Opcode_i == OP_LOAD);
                mem_write = (Opcode_i != OP_LOAD);
                if (DMem_Ready_i) begin
                    if (Opcode_i == OP_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end else if (timer_expired) begin
                    state_d = ST_TRAP;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = ST_FETCH;
                if (Opcode_i == OP_LOAD) begin
                    wb_sel = WB_SEL_MEM;
                end else if (Opcode_i == OP_JAL || Opcode_i == OP_JALR) begin
                    wb_sel = WB_SEL_PC4;
                end
                if (Opcode_i == OP_JAL) begin
                    pc_src = PC_SRC_IMM;
                end else if (Opcode_i == OP_JALR) begin
                    pc_src = PC_SRC_ALU;
                end
            end
            ST_TRAP: ;
            default: state_d = ST_TRAP;
        endcase
    end

    // Any state change starts a fresh wait window in the destination state.
    assign timer_clr = (state_d != state_q);

    // Every retirement coincides with exactly one PC write.
    assign instret_d = pc_write ? instret_q + INSTRET_WIDTH'(1) : instret_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    wait_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (timer_clr),
        .inc_i     (timer_inc),
        .expired_o (timer_expired)
    );

    // Gating with reset makes strobes drop the moment reset asserts,
    // including the FETCH read request that the reset state would imply.
    assign IMem_Read_o = reset & imem_read;
    assign IR_Write_o  = reset & ir_write;
    assign PC_Write_o  = reset & pc_write;
    assign PC_Src_o    = reset ? pc_src : PC_SRC_PLUS4;
    assign ALU_Src_o   = reset & alu_src;
    assign ALU_Op_o    = reset ? alu_op : 3'd0;
    assign Mem_Read_o  = reset & mem_read;
    assign Mem_Write_o = reset & mem_write;
    assign Reg_Write_o = reset & reg_write;
    assign Wb_Sel_o    = reset ? wb_sel : WB_SEL_ALU;
    assign Trap_o      = (state_q == ST_TRAP);
    assign Instret_o   = instret_q;
    assign State_o     = state_q;

endmodule
